// File: rtl/dccm_dma_rmw.sv
// DMA-side sequencer for the DCCM port: reads, full writes and byte-masked
// read-modify-writes with SECDED correction/regeneration; yields to the LSU.
//
// state | meaning
// IDLE  | ready for a request
// RD    | issue dccm_rden (held off while the LSU owns the port)
// WAIT  | count down the read latency, then sample and decode
// WR    | issue dccm_wren (held off while the LSU owns the port)
// RSP   | response presented until rsp_ready
module dccm_dma_rmw #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  dec_tlu_core_ecc_disable,
  input  logic                  lsu_dccm_active,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_byteen,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  dccm_rden,
  output logic                  dccm_wren,
  output logic [ADDR_WIDTH-1:0] dccm_rd_addr_lo,
  output logic [ADDR_WIDTH-1:0] dccm_rd_addr_hi,
  output logic [ADDR_WIDTH-1:0] dccm_wr_addr,
  output logic [38:0]           dccm_wr_data,
  input  logic [38:0]           dccm_rd_data_lo
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RSP} state_t;

  // Hamming code over positions 1..38; check bits sit at the power-of-two
  // positions, data bits fill the rest in ascending order.
  function automatic logic [31:0] chk_mask(input int k);
    logic [31:0] m;
    logic [4:0]  j;
    m = '0;
    j = '0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        m[j] = (((p >> k) & 1) != 0);
        j    = j + 5'd1;
      end
    end
    return m;
  endfunction

  localparam logic [5:0][31:0] CHK_MASK = {chk_mask(5), chk_mask(4), chk_mask(3),
                                           chk_mask(2), chk_mask(1), chk_mask(0)};

  function automatic logic [6:0] ecc_encode(input logic [31:0] d);
    logic [5:0] c;
    for (int k = 0; k < 6; k++) c[k] = ^(d & CHK_MASK[k]);
    return {^{d, c}, c};
  endfunction

  state_t                state;
  logic [1:0]            lat_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [3:0]            byteen_q;
  logic [31:0]           wdata_q;

  logic [31:0] rd_word;
  logic [6:0]  rd_recalc;
  logic [5:0]  syndrome;
  logic [5:0]  col;
  logic        parity_odd;
  logic        ecc_on;
  logic        dbl_err;
  logic [31:0] corr_data;
  logic [31:0] merged;
  logic [31:0] enc_data;
  logic [6:0]  enc_ecc;
  logic        unused_bits;

  always_comb begin
    rd_word    = dccm_rd_data_lo[31:0];
    rd_recalc  = ecc_encode(rd_word);
    syndrome   = dccm_rd_data_lo[37:32] ^ rd_recalc[5:0];
    parity_odd = ^dccm_rd_data_lo;
    ecc_on     = ~dec_tlu_core_ecc_disable;
    corr_data  = rd_word;
    col        = '0;
    // Odd overall parity means a single flip; a zero syndrome then points at ecc[6].
    for (int j = 0; j < 32; j++) begin
      for (int k = 0; k < 6; k++) col[k] = CHK_MASK[k][j];
      if (ecc_on && parity_odd && (syndrome == col)) corr_data[j] = ~rd_word[j];
    end
    dbl_err = ecc_on && !parity_odd && (syndrome != 6'd0);
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = byteen_q[b] ? wdata_q[8*b +: 8] : corr_data[8*b +: 8];
    end
    enc_data = (state == WAIT) ? merged : req_wdata;
    enc_ecc  = ecc_encode(enc_data);
  end

  assign unused_bits = ^{req_addr[1:0], rd_recalc[6]};

  assign dccm_rden       = (state == RD) && !lsu_dccm_active;
  assign dccm_wren       = (state == WR) && !lsu_dccm_active;
  assign dccm_rd_addr_lo = addr_q;
  assign dccm_rd_addr_hi = addr_q;
  assign dccm_wr_addr    = addr_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      byteen_q     <= '0;
      wdata_q      <= '0;
      dccm_wr_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_q    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            write_q   <= req_write;
            byteen_q  <= req_byteen;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (req_write && (req_byteen == 4'hF)) begin
              dccm_wr_data <= {enc_ecc, req_wdata};
              state        <= WR;
            end else if (req_write && (req_byteen == 4'h0)) begin
              rsp_valid <= 1'b1;
              state     <= RSP;
            end else begin
              state <= RD;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          if (!lsu_dccm_active) begin
            lat_cnt <= 2'(RD_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else if (dbl_err) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= write_q ? 32'd0 : rd_word;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else if (write_q) begin
            dccm_wr_data <= {enc_ecc, merged};
            state        <= WR;
          end else begin
            rsp_rdata <= corr_data;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        WR: begin
          if (!lsu_dccm_active) begin
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dccm_dma_rmw.sv
// Bench for dccm_dma_rmw: directed vector table, contention/stall/reset
// sequences, and randomized traffic against a word-level memory model.
module tb_dccm_dma_rmw;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        dec_tlu_core_ecc_disable = 1'b0;
  logic        lsu_dccm_active;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_byteen = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dccm_rden;
  logic        dccm_wren;
  logic [15:0] dccm_rd_addr_lo;
  logic [15:0] dccm_rd_addr_hi;
  logic [15:0] dccm_wr_addr;
  logic [38:0] dccm_wr_data;
  logic [38:0] rd_data = '0;

  logic lsu_dir = 1'b0;
  logic lsu_r = 1'b0;
  logic lsu_rand = 1'b0;
  assign lsu_dccm_active = lsu_rand ? lsu_r : lsu_dir;

  dccm_dma_rmw #(.ADDR_WIDTH(16), .RD_LAT(1)) dut (
    .clk(clk), .rst_l(rst_l),
    .dec_tlu_core_ecc_disable(dec_tlu_core_ecc_disable),
    .lsu_dccm_active(lsu_dccm_active),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dccm_rden(dccm_rden), .dccm_wren(dccm_wren),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .dccm_rd_data_lo(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) lsu_r <= ($urandom_range(0, 3) == 0);

  // DCCM model: one-cycle read latency, poke port for preloading/corruption.
  logic [38:0] mem [1024];
  logic        poke_en = 1'b0;
  logic [9:0]  poke_idx = '0;
  logic [38:0] poke_val = '0;
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (dccm_wren) mem[dccm_wr_addr[11:2]] <= dccm_wr_data;
    if (dccm_rden) rd_data <= mem[dccm_rd_addr_lo[11:2]];
  end

  int          rden_cnt = 0, wren_cnt = 0, last_rden = 0, last_wren = 0, viol = 0;
  logic [15:0] last_rd_addr = '0, last_wr_addr = '0;
  always @(negedge clk) begin
    if (dccm_rden) begin rden_cnt++; last_rden = cyc; last_rd_addr = dccm_rd_addr_lo; end
    if (dccm_wren) begin wren_cnt++; last_wren = cyc; last_wr_addr = dccm_wr_addr; end
    if ((dccm_rden && dccm_wren) || ((dccm_rden || dccm_wren) && lsu_dccm_active) ||
        (dccm_rden && (dccm_rd_addr_hi != dccm_rd_addr_lo)) ||
        (dccm_rden && (dccm_rd_addr_lo[1:0] != 2'b00)) ||
        (dccm_wren && (dccm_wr_addr[1:0] != 2'b00)))
      viol++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Codeword whose set-bit positions XOR to zero, plus overall even parity.
  function automatic logic [6:0] tb_enc(input logic [31:0] d);
    logic [5:0] x;
    int j;
    x = '0;
    j = 0;
    for (int p = 1; p <= 38; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
        if (d[j[4:0]]) x = x ^ 6'(p);
        j++;
      end
    end
    return {(^d) ^ (^x), x};
  endfunction

  function automatic logic [38:0] cw(input logic [31:0] d);
    return {tb_enc(d), d};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic poke(input logic [9:0] i, input logic [38:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = i; poke_val = v;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [15:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int n);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = w; req_addr = a; req_byteen = be; req_wdata = wd;
    n = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int hold, input logic [31:0] exp_rd, input logic exp_err, output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    t = cyc;
    chk("rsp_valid_seen", 64'(rsp_valid), 64'(1));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
      chk("hold_err", 64'(rsp_err), 64'(exp_err));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, rsp_valid, rsp_err, dccm_rden, dccm_wren}), 64'(0));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({tag, "_wr_data"}, 64'(dccm_wr_data), 64'(0));
    chk({tag, "_addrs"}, 64'({dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr}), 64'(0));
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        dis;
    logic [38:0] pre;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          rsp_lat;
    int          rden_lat;
    int          wren_lat;
    logic [38:0] exp_mem;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  logic [31:0] ref_mem [16];
  logic        dirty [16];

  initial begin
    int n, t, r0, w0, k, idx, op, hold;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [38:0] p2, p4, p7;

    p2 = cw(32'hCAFEF00D) ^ (39'd1 << 5);
    p4 = cw(32'hA5A5A5A5) ^ 39'd3;
    p7 = cw(32'h44332211) ^ (39'd1 << 20);
    vecs[0] = '{1'b1, 16'h0104, 4'hF, 32'hDEADBEEF, 1'b0, 39'd0, 32'h0, 1'b0, 2, -1, 1, cw(32'hDEADBEEF)};
    vecs[1] = '{1'b1, 16'h0200, 4'b0101, 32'hAABBCCDD, 1'b0, cw(32'h11223344), 32'h0, 1'b0, 4, 1, 3, cw(32'h11BB33DD)};
    vecs[2] = '{1'b0, 16'h0300, 4'h0, 32'h0, 1'b0, p2, 32'hCAFEF00D, 1'b0, 3, 1, -1, p2};
    vecs[3] = '{1'b0, 16'h0300, 4'h0, 32'h0, 1'b1, p2, 32'hCAFEF02D, 1'b0, 3, 1, -1, p2};
    vecs[4] = '{1'b1, 16'h0400, 4'b0011, 32'h12345678, 1'b0, p4, 32'h0, 1'b1, 3, 1, -1, p4};
    vecs[5] = '{1'b1, 16'h0500, 4'h0, 32'hFFFFFFFF, 1'b0, cw(32'h01020304), 32'h0, 1'b0, 1, -1, -1, cw(32'h01020304)};
    vecs[6] = '{1'b0, 16'h0600, 4'h0, 32'h0, 1'b0, cw(32'h0F0F0F0F) ^ (39'd1 << 38), 32'h0F0F0F0F, 1'b0, 3, 1, -1, cw(32'h0F0F0F0F) ^ (39'd1 << 38)};
    vecs[7] = '{1'b1, 16'h0700, 4'b1000, 32'h99000000, 1'b0, p7, 32'h0, 1'b0, 4, 1, 3, cw(32'h99332211)};
    vecs[8] = '{1'b0, 16'h0800, 4'h0, 32'h0, 1'b1, cw(32'h55555555) ^ 39'd3, 32'h55555556, 1'b0, 3, 1, -1, cw(32'h55555555) ^ 39'd3};
    vecs[9] = '{1'b0, 16'h0903, 4'hF, 32'h0, 1'b0, cw(32'h600DF00D), 32'h600DF00D, 1'b0, 3, 1, -1, cw(32'h600DF00D)};

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_l = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'(1));

    for (int i = 0; i < NV; i++) begin
      poke(vecs[i].a[11:2], vecs[i].pre);
      dec_tlu_core_ecc_disable = vecs[i].dis;
      r0 = rden_cnt; w0 = wren_cnt;
      do_req(vecs[i].w, vecs[i].a, vecs[i].be, vecs[i].wd, n);
      wait_rsp(0, vecs[i].exp_rd, vecs[i].exp_err, t);
      chk($sformatf("v%0d_rsp_lat", i), 64'(t - n), 64'(vecs[i].rsp_lat));
      chk($sformatf("v%0d_rden_cnt", i), 64'(rden_cnt - r0), 64'(vecs[i].rden_lat >= 0 ? 1 : 0));
      chk($sformatf("v%0d_wren_cnt", i), 64'(wren_cnt - w0), 64'(vecs[i].wren_lat >= 0 ? 1 : 0));
      if (vecs[i].rden_lat >= 0) begin
        chk($sformatf("v%0d_rden_lat", i), 64'(last_rden - n), 64'(vecs[i].rden_lat));
        chk($sformatf("v%0d_rd_addr", i), 64'(last_rd_addr), 64'({vecs[i].a[15:2], 2'b00}));
      end
      if (vecs[i].wren_lat >= 0) begin
        chk($sformatf("v%0d_wren_lat", i), 64'(last_wren - n), 64'(vecs[i].wren_lat));
        chk($sformatf("v%0d_wr_addr", i), 64'(last_wr_addr), 64'({vecs[i].a[15:2], 2'b00}));
      end
      chk($sformatf("v%0d_mem", i), 64'(mem[vecs[i].a[11:2]]), 64'(vecs[i].exp_mem));
    end
    dec_tlu_core_ecc_disable = 1'b0;

    // Full write blocked by the LSU for three cycles, then a 5-cycle response stall.
    w0 = wren_cnt;
    do_req(1'b1, 16'h0A00, 4'hF, 32'h13579BDF, n);
    lsu_dir = 1'b1;
    repeat (3) @(posedge clk);
    #1 lsu_dir = 1'b0;
    wait_rsp(5, 32'h0, 1'b0, t);
    chk("lsu_wren_lat", 64'(last_wren - n), 64'(4));
    chk("lsu_wren_cnt", 64'(wren_cnt - w0), 64'(1));
    chk("lsu_rsp_lat", 64'(t - n), 64'(5));
    chk("lsu_mem", 64'(mem[10'h280]), 64'(cw(32'h13579BDF)));

    // RMW: read blocked two cycles, LSU activity during WAIT must not matter.
    poke(10'h2C0, cw(32'hDEADC0DE));
    r0 = rden_cnt; w0 = wren_cnt;
    do_req(1'b1, 16'h0B00, 4'b0001, 32'h000000AA, n);
    lsu_dir = 1'b1;
    repeat (2) @(posedge clk);
    #1 lsu_dir = 1'b0;
    @(posedge clk);
    #1 lsu_dir = 1'b1;
    @(posedge clk);
    #1 lsu_dir = 1'b0;
    wait_rsp(0, 32'h0, 1'b0, t);
    chk("rmw_lsu_rden_lat", 64'(last_rden - n), 64'(3));
    chk("rmw_lsu_wren_lat", 64'(last_wren - n), 64'(5));
    chk("rmw_lsu_counts", 64'({16'(rden_cnt - r0), 16'(wren_cnt - w0)}), 64'({16'd1, 16'd1}));
    chk("rmw_lsu_rsp_lat", 64'(t - n), 64'(6));
    chk("rmw_lsu_mem", 64'(mem[10'h2C0]), 64'(cw(32'hDEADC0AA)));

    // Reset while an RMW sits in WAIT.
    poke(10'h300, cw(32'h12121212));
    w0 = wren_cnt;
    do_req(1'b1, 16'h0C00, 4'b0010, 32'h0000FF00, n);
    @(posedge clk);
    #2 rst_l = 1'b0;
    #1 chk_idle_outputs("async_reset");
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    k = 0;
    while (!req_ready && k < 10) begin @(negedge clk); k++; end
    chk("idle_after_reset", 64'(req_ready), 64'(1));
    chk("reset_no_wren", 64'(wren_cnt - w0), 64'(0));
    chk("reset_mem_kept", 64'(mem[10'h300]), 64'(cw(32'h12121212)));
    do_req(1'b0, 16'h0C00, 4'h0, 32'h0, n);
    wait_rsp(0, 32'h12121212, 1'b0, t);

    // Randomized traffic against the word-level reference memory.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      dirty[i] = 1'b0;
      poke(10'(i), cw(ref_mem[i]));
    end
    lsu_rand = 1'b1;
    for (int it = 0; it < 200; it++) begin
      idx = $urandom_range(0, 15);
      a = 16'(idx * 4 + $urandom_range(0, 3));
      hold = $urandom_range(0, 2);
      if (!dirty[idx] && $urandom_range(0, 4) == 0) begin
        poke(10'(idx), cw(ref_mem[idx]) ^ (39'd1 << $urandom_range(0, 38)));
        dirty[idx] = 1'b1;
      end
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_req(1'b0, a, 4'($urandom_range(0, 15)), $urandom, n);
        wait_rsp(hold, ref_mem[idx], 1'b0, t);
      end else begin
        wd = $urandom;
        be = (op == 1) ? 4'hF : 4'($urandom_range(0, 15));
        ref_mem[idx] = merge(ref_mem[idx], wd, be);
        if (be != 4'h0) dirty[idx] = 1'b0;
        do_req(1'b1, a, be, wd, n);
        wait_rsp(hold, 32'h0, 1'b0, t);
      end
    end
    lsu_rand = 1'b0;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 16'(i * 4), 4'h0, 32'h0, n);
      wait_rsp(0, ref_mem[i], 1'b0, t);
    end

    chk("strobe_rules", 64'(viol), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
